// File: rtl/ahb_matrix_decode_param.sv
// ahb_matrix_decode_param
// Per-slave-interface address decoder for the AHB bus matrix.
// - Compares HADDR[31:10] against per-port base/mask regions. The lowest
//   index wins on overlap, and unmapped accesses go to an internal default
//   slave.
// - The default slave answers NONSEQ/SEQ with a two-cycle ERROR and answers
//   IDLE/BUSY with a zero-wait OKAY.
// - The data-phase port is registered, and the selected output stage's
//   response is muxed back to the input stage.
// Optional feature, enabled with macro AHB_MATRIX_DECODE_ERRCAP_EN: a sticky
// first-error address capture, read out on err_valid/err_addr and cleared
// with err_clr.
// PW must satisfy 2**PW > NUM_PORTS so that the default-slave index
// (NUM_PORTS) can be represented.

module ahb_matrix_decode_param #(
    parameter int                         NUM_PORTS   = 1,
    parameter int                         DATA_WIDTH  = 32,
    parameter int                         USER_WIDTH  = 32,
    parameter logic [22*NUM_PORTS-1:0]    REGION_BASE = {NUM_PORTS{22'h0}},
    parameter logic [22*NUM_PORTS-1:0]    REGION_MASK = {NUM_PORTS{22'h3FFFC0}},
    parameter int                         PW          = 3
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             HREADYS,
    input  logic                             sel_dec,
    input  logic [21:0]                      decode_addr_dec,
    input  logic [1:0]                       trans_dec,
    input  logic [NUM_PORTS-1:0]             active_dec_i,
    input  logic [NUM_PORTS-1:0]             readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]           resp_dec_i,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]  rdata_dec_i,
    input  logic [USER_WIDTH*NUM_PORTS-1:0]  ruser_dec_i,
`ifdef AHB_MATRIX_DECODE_ERRCAP_EN
    input  logic                             err_clr,
    output logic                             err_valid,
    output logic [21:0]                      err_addr,
`endif
    output logic [NUM_PORTS-1:0]             sel_dec_o,
    output logic                             active_dec,
    output logic                             HREADYOUTS,
    output logic [1:0]                       HRESPS,
    output logic [DATA_WIDTH-1:0]            HRDATAS,
    output logic [USER_WIDTH-1:0]            HRUSERS
);

    localparam logic [PW-1:0] DFT       = PW'(NUM_PORTS);
    localparam logic [1:0]    RESP_OKAY = 2'b00;
    localparam logic [1:0]    RESP_ERR  = 2'b01;
    localparam logic [1:0]    TRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    ds_state_t       ds_state;
    ds_state_t       ds_next;
    logic [PW-1:0]   hit_port;
    logic [PW-1:0]   addr_port;
    logic [PW-1:0]   data_port;
    logic            sel_dft;
    logic            ds_ready;
    logic [1:0]      ds_resp;

    // Region compare; scanning from the top down lets the lowest index win.
    always_comb begin
        hit_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if ((decode_addr_dec & REGION_MASK[i*22 +: 22]) ==
                (REGION_BASE[i*22 +: 22] & REGION_MASK[i*22 +: 22])) begin
                hit_port = PW'(i);
            end
        end
    end

    // An IDLE keeps the current data-phase slave selected.
    always_comb begin
        if ((data_port != DFT) && (trans_dec == TRANS_IDLE)) begin
            addr_port = data_port;
        end else begin
            addr_port = hit_port;
        end
    end

    // One-hot select and active flag; the default slave always reads as active.
    always_comb begin
        sel_dec_o  = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == PW'(i)) begin
                sel_dec_o[i] = sel_dec;
                active_dec   = active_dec_i[i];
            end
        end
        sel_dft = sel_dec & (addr_port == DFT);
    end

    // The data-phase port advances on the matrix-wide HREADYS, not on the muxed HREADYOUTS.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_port <= '0;
        end else if (HREADYS) begin
            data_port <= addr_port;
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default-slave next state and its two-cycle ERROR response.
    always_comb begin
        ds_next  = ds_state;
        ds_ready = 1'b1;
        ds_resp  = RESP_OKAY;
        case (ds_state)
            DS_IDLE: begin
                if (sel_dft && HREADYS && trans_dec[1]) begin
                    ds_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = RESP_ERR;
                ds_next  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp = RESP_ERR;
                if (sel_dft && HREADYS && trans_dec[1]) begin
                    ds_next = DS_ERR1;
                end else begin
                    ds_next = DS_IDLE;
                end
            end
            default: begin
                ds_next = DS_IDLE;
            end
        endcase
    end

    // Return-path mux; a data_port beyond DFT is unreachable and yields X.
    always_comb begin
        HREADYOUTS = 1'bx;
        HRESPS     = 'x;
        HRDATAS    = 'x;
        HRUSERS    = 'x;
        if (data_port == DFT) begin
            HREADYOUTS = ds_ready;
            HRESPS     = ds_resp;
            HRDATAS    = '0;
            HRUSERS    = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == PW'(i)) begin
                HREADYOUTS = readyout_dec_i[i];
                HRESPS     = resp_dec_i[i*2 +: 2];
                HRDATAS    = rdata_dec_i[i*DATA_WIDTH +: DATA_WIDTH];
                HRUSERS    = ruser_dec_i[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

`ifdef AHB_MATRIX_DECODE_ERRCAP_EN
    logic err_start;

    always_comb begin
        err_start = (ds_next == DS_ERR1) && (ds_state != DS_ERR1);
    end

    // Sticky first-error capture; a capture coinciding with a clear wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_start && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= decode_addr_dec;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule
